axi_master_read_dma: RTL and testbench

AXI_MASTER_READ_DMA -- requirements
Module: axi_master_read_dma

---
 rtl/axi_master_read_dma_pkg.sv | 25 ++
 rtl/axi_master_read_dma_rstn_sync.sv | 20 ++
 rtl/axi_master_read_dma.sv | 153 +++++++++++++++
 tb/tb_axi_master_read_dma.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_read_dma_pkg.sv
// Definitions shared by the read and write AXI DMA masters: FSM states,
// the longest INCR burst, and the burst-length rule for a ring window.
package axi_master_read_dma_pkg;

    typedef enum logic [1:0] {
        FIRST_LOAD = 2'd0,
        IDLE       = 2'd1,
        RD_ADDR    = 2'd2,
        RD_DATA    = 2'd3
    } dma_state_t;

    localparam logic [7:0] MAX_BURST_LEN = 8'hFF;
    localparam logic [1:0] BURST_INCR    = 2'b01;

    // Beats-1 for a burst starting at base that must not run past last.
    function automatic logic [7:0] burst_len(input logic [31:0] base,
                                             input logic [31:0] last);
        logic [31:0] span;
        span = last - base;
        if (base + {24'd0, MAX_BURST_LEN} > last)
            return span[7:0];
        return MAX_BURST_LEN;
    endfunction

endpackage

// File: rtl/axi_master_read_dma_rstn_sync.sv
// Reset synchronizer: asserts asynchronously, releases two clk edges after rstn rises.
module rstn_sync (
    input  logic clk,
    input  logic rstn,
    output logic sync_rstn
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta      <= 1'b0;
            sync_rstn <= 1'b0;
        end else begin
            meta      <= 1'b1;
            sync_rstn <= meta;
        end
    end

endmodule

// File: rtl/axi_master_read_dma.sv
// AXI4 read master that streams a ring window of words into a downstream FIFO,
// one INCR burst of up to 256 beats at a time.
module axi_master_read_dma
    import axi_master_read_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] START_READ_ADDR,
    input  logic [31:0] END_READ_ADDR,
    output logic        wr_clk,
    input  logic        wr_capture_on,
    input  logic        wr_capture_rst,
    input  logic        wr_data_ready,
    output logic        wr_data_valid,
    output logic [31:0] wr_data,
    output logic        MASTER_CLK,
    output logic        MASTER_RSTN,
    output logic [1:0]  MASTER_WR_ADDR_ID,
    output logic [31:0] MASTER_WR_ADDR,
    output logic [7:0]  MASTER_WR_ADDR_LEN,
    output logic [1:0]  MASTER_WR_ADDR_BURST,
    output logic        MASTER_WR_ADDR_VALID,
    input  logic        MASTER_WR_ADDR_READY,
    output logic [31:0] MASTER_WR_DATA,
    output logic [3:0]  MASTER_WR_DATA_STRB,
    output logic        MASTER_WR_DATA_LAST,
    output logic        MASTER_WR_DATA_VALID,
    input  logic        MASTER_WR_DATA_READY,
    input  logic [1:0]  MASTER_WR_BACK_ID,
    input  logic [1:0]  MASTER_WR_BACK_RESP,
    input  logic        MASTER_WR_BACK_VALID,
    output logic        MASTER_WR_BACK_READY,
    output logic [1:0]  MASTER_RD_ADDR_ID,
    output logic [31:0] MASTER_RD_ADDR,
    output logic [7:0]  MASTER_RD_ADDR_LEN,
    output logic [1:0]  MASTER_RD_ADDR_BURST,
    output logic        MASTER_RD_ADDR_VALID,
    input  logic        MASTER_RD_ADDR_READY,
    input  logic [1:0]  MASTER_RD_BACK_ID,
    input  logic [31:0] MASTER_RD_DATA,
    input  logic [1:0]  MASTER_RD_DATA_RESP,
    input  logic        MASTER_RD_DATA_LAST,
    input  logic        MASTER_RD_DATA_VALID,
    output logic        MASTER_RD_DATA_READY
);

    logic        dma_rstn_sync;
    dma_state_t  state;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  beat_cnt;
    logic        drop;
    logic        ar_valid;
    logic        in_data;
    logic        r_hs;
    logic [31:0] addr_step;
    logic        unused_inputs;

    rstn_sync u_rstn_sync (
        .clk       (clk),
        .rstn      (rstn),
        .sync_rstn (dma_rstn_sync)
    );

    assign wr_clk      = clk;
    assign MASTER_CLK  = clk;
    assign MASTER_RSTN = dma_rstn_sync;

    // The write channel is unused by this direction and parked idle.
    assign MASTER_WR_ADDR_ID    = 2'd0;
    assign MASTER_WR_ADDR       = 32'd0;
    assign MASTER_WR_ADDR_LEN   = 8'd0;
    assign MASTER_WR_ADDR_BURST = 2'd0;
    assign MASTER_WR_ADDR_VALID = 1'b0;
    assign MASTER_WR_DATA       = 32'd0;
    assign MASTER_WR_DATA_STRB  = 4'd0;
    assign MASTER_WR_DATA_LAST  = 1'b0;
    assign MASTER_WR_DATA_VALID = 1'b0;
    assign MASTER_WR_BACK_READY = 1'b1;

    assign unused_inputs = ^{MASTER_WR_ADDR_READY, MASTER_WR_DATA_READY, MASTER_WR_BACK_ID,
                             MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID, MASTER_RD_BACK_ID,
                             MASTER_RD_DATA_RESP};

    assign MASTER_RD_ADDR_ID    = 2'd0;
    assign MASTER_RD_ADDR_BURST = BURST_INCR;
    assign MASTER_RD_ADDR       = addr;
    assign MASTER_RD_ADDR_LEN   = len;
    assign MASTER_RD_ADDR_VALID = ar_valid;

    // While draining after a restart the R channel is always accepted but nothing reaches the FIFO.
    assign in_data              = (state == RD_DATA);
    assign MASTER_RD_DATA_READY = in_data & (wr_data_ready | drop);
    assign wr_data_valid        = in_data & MASTER_RD_DATA_VALID & wr_data_ready & ~drop;
    assign wr_data              = MASTER_RD_DATA;
    assign r_hs                 = MASTER_RD_DATA_VALID & MASTER_RD_DATA_READY;

    assign addr_step = addr + {24'd0, len} + 32'd1;

    always_ff @(posedge clk or negedge dma_rstn_sync) begin
        if (!dma_rstn_sync) begin
            state    <= FIRST_LOAD;
            addr     <= 32'd0;
            len      <= 8'd0;
            beat_cnt <= 8'd0;
            drop     <= 1'b0;
            ar_valid <= 1'b0;
        end else begin
            if (wr_capture_rst)
                drop <= 1'b1;
            else if (state == FIRST_LOAD)
                drop <= 1'b0;

            case (state)
                FIRST_LOAD: begin
                    if (wr_capture_on && !wr_capture_rst) begin
                        addr     <= START_READ_ADDR;
                        len      <= burst_len(START_READ_ADDR, END_READ_ADDR);
                        ar_valid <= 1'b1;
                        state    <= RD_ADDR;
                    end
                end
                IDLE: begin
                    if (wr_capture_rst || drop) begin
                        state <= FIRST_LOAD;
                    end else if (wr_capture_on) begin
                        len      <= burst_len(addr, END_READ_ADDR);
                        ar_valid <= 1'b1;
                        state    <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (MASTER_RD_ADDR_READY) begin
                        ar_valid <= 1'b0;
                        beat_cnt <= len;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if (MASTER_RD_DATA_LAST) begin
                            addr  <= (addr_step > END_READ_ADDR) ? START_READ_ADDR : addr_step;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= FIRST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_read_dma.sv
// Directed-random bench: a word-addressed AXI slave plus a ring-window reference model.
`timescale 1ns/1ps
module tb_axi_master_read_dma;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] START_READ_ADDR = 32'd0;
    logic [31:0] END_READ_ADDR = 32'd0;
    logic        wr_clk;
    logic        wr_capture_on = 1'b0;
    logic        wr_capture_rst = 1'b0;
    logic        wr_data_ready = 1'b1;
    logic        wr_data_valid;
    logic [31:0] wr_data;
    logic        MASTER_CLK, MASTER_RSTN;
    logic [1:0]  MASTER_WR_ADDR_ID;
    logic [31:0] MASTER_WR_ADDR;
    logic [7:0]  MASTER_WR_ADDR_LEN;
    logic [1:0]  MASTER_WR_ADDR_BURST;
    logic        MASTER_WR_ADDR_VALID;
    logic [31:0] MASTER_WR_DATA;
    logic [3:0]  MASTER_WR_DATA_STRB;
    logic        MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID, MASTER_WR_BACK_READY;
    logic [1:0]  MASTER_RD_ADDR_ID;
    logic [31:0] MASTER_RD_ADDR;
    logic [7:0]  MASTER_RD_ADDR_LEN;
    logic [1:0]  MASTER_RD_ADDR_BURST;
    logic        MASTER_RD_ADDR_VALID;
    logic        MASTER_RD_ADDR_READY = 1'b0;
    logic [31:0] MASTER_RD_DATA = 32'd0;
    logic        MASTER_RD_DATA_LAST = 1'b0;
    logic        MASTER_RD_DATA_VALID = 1'b0;
    logic        MASTER_RD_DATA_READY;

    axi_master_read_dma dut (
        .clk(clk), .rstn(rstn),
        .START_READ_ADDR(START_READ_ADDR), .END_READ_ADDR(END_READ_ADDR),
        .wr_clk(wr_clk), .wr_capture_on(wr_capture_on), .wr_capture_rst(wr_capture_rst),
        .wr_data_ready(wr_data_ready), .wr_data_valid(wr_data_valid), .wr_data(wr_data),
        .MASTER_CLK(MASTER_CLK), .MASTER_RSTN(MASTER_RSTN),
        .MASTER_WR_ADDR_ID(MASTER_WR_ADDR_ID), .MASTER_WR_ADDR(MASTER_WR_ADDR),
        .MASTER_WR_ADDR_LEN(MASTER_WR_ADDR_LEN), .MASTER_WR_ADDR_BURST(MASTER_WR_ADDR_BURST),
        .MASTER_WR_ADDR_VALID(MASTER_WR_ADDR_VALID), .MASTER_WR_ADDR_READY(1'b0),
        .MASTER_WR_DATA(MASTER_WR_DATA), .MASTER_WR_DATA_STRB(MASTER_WR_DATA_STRB),
        .MASTER_WR_DATA_LAST(MASTER_WR_DATA_LAST), .MASTER_WR_DATA_VALID(MASTER_WR_DATA_VALID),
        .MASTER_WR_DATA_READY(1'b0), .MASTER_WR_BACK_ID(2'd0), .MASTER_WR_BACK_RESP(2'd0),
        .MASTER_WR_BACK_VALID(1'b0), .MASTER_WR_BACK_READY(MASTER_WR_BACK_READY),
        .MASTER_RD_ADDR_ID(MASTER_RD_ADDR_ID), .MASTER_RD_ADDR(MASTER_RD_ADDR),
        .MASTER_RD_ADDR_LEN(MASTER_RD_ADDR_LEN), .MASTER_RD_ADDR_BURST(MASTER_RD_ADDR_BURST),
        .MASTER_RD_ADDR_VALID(MASTER_RD_ADDR_VALID), .MASTER_RD_ADDR_READY(MASTER_RD_ADDR_READY),
        .MASTER_RD_BACK_ID(2'b11), .MASTER_RD_DATA(MASTER_RD_DATA), .MASTER_RD_DATA_RESP(2'b10),
        .MASTER_RD_DATA_LAST(MASTER_RD_DATA_LAST), .MASTER_RD_DATA_VALID(MASTER_RD_DATA_VALID),
        .MASTER_RD_DATA_READY(MASTER_RD_DATA_READY)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    // Observed traffic (monitor only appends; scenarios use start offsets).
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [31:0] word_q[$];
    logic [31:0] sl_addr_q[$];
    logic [7:0]  sl_len_q[$];
    int          sl_beat = 0;
    int          total_rhs = 0;
    int          dropped_beats = 0;
    int          mirror_err = 0;
    int          data_err = 0;
    int          ar_stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_ar_addr = 32'd0;
    logic [7:0]  prev_ar_len = 8'd0;

    // Stimulus knobs, written only by the main sequence.
    int          ready_mode = 0;
    int          valid_pct = 70;
    bit          expect_drop = 1'b0;
    int          drv_seen_rhs = 0;

    // Reference model.
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    logic [31:0] exp_word_q[$];
    logic [31:0] model_ptr = 32'd0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            sl_addr_q.delete();
            sl_len_q.delete();
            sl_beat = 0;
            prev_stall = 1'b0;
        end else begin
            if (sl_addr_q.size() > 0 && !expect_drop && MASTER_RD_DATA_READY !== wr_data_ready)
                mirror_err++;
            if (wr_data_valid === 1'b1) begin
                word_q.push_back(wr_data);
                if (wr_data !== MASTER_RD_DATA || MASTER_RD_DATA_READY !== 1'b1 ||
                    MASTER_RD_DATA_VALID !== 1'b1)
                    data_err++;
            end
            if (prev_stall && (MASTER_RD_ADDR_VALID !== 1'b1 || MASTER_RD_ADDR !== prev_ar_addr ||
                               MASTER_RD_ADDR_LEN !== prev_ar_len))
                ar_stab_err++;
            prev_stall   = (MASTER_RD_ADDR_VALID === 1'b1) && (MASTER_RD_ADDR_READY === 1'b0);
            prev_ar_addr = MASTER_RD_ADDR;
            prev_ar_len  = MASTER_RD_ADDR_LEN;
            if (MASTER_RD_DATA_VALID === 1'b1 && MASTER_RD_DATA_READY === 1'b1) begin
                total_rhs++;
                if (wr_data_valid !== 1'b1) dropped_beats++;
                if (MASTER_RD_DATA_LAST === 1'b1) begin
                    void'(sl_addr_q.pop_front());
                    void'(sl_len_q.pop_front());
                    sl_beat = 0;
                end else begin
                    sl_beat++;
                end
            end
            if (MASTER_RD_ADDR_VALID === 1'b1 && MASTER_RD_ADDR_READY === 1'b1) begin
                ar_addr_q.push_back(MASTER_RD_ADDR);
                ar_len_q.push_back(MASTER_RD_ADDR_LEN);
                sl_addr_q.push_back(MASTER_RD_ADDR);
                sl_len_q.push_back(MASTER_RD_ADDR_LEN);
            end
        end
    end

    // Slave and FIFO-side driver; RVALID is held until its beat is taken.
    always begin
        @(posedge clk);
        #1;
        MASTER_RD_ADDR_READY = ($urandom_range(99) < 60);
        case (ready_mode)
            0:       wr_data_ready = 1'b1;
            1:       wr_data_ready = ~wr_data_ready;
            default: wr_data_ready = ($urandom_range(99) < 70);
        endcase
        if (sl_addr_q.size() == 0) begin
            MASTER_RD_DATA_VALID = 1'b0;
            MASTER_RD_DATA_LAST  = 1'b0;
        end else if (!(MASTER_RD_DATA_VALID && total_rhs == drv_seen_rhs)) begin
            MASTER_RD_DATA_VALID = ($urandom_range(99) < 32'(valid_pct));
            MASTER_RD_DATA       = mem(sl_addr_q[0] + 32'(sl_beat));
            MASTER_RD_DATA_LAST  = (sl_beat == int'(sl_len_q[0]));
        end
        drv_seen_rhs = total_rhs;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_burst(input logic [31:0] a, input logic [7:0] l, input int nwords);
        exp_addr_q.push_back(a);
        exp_len_q.push_back(l);
        for (int j = 0; j < nwords; j++) exp_word_q.push_back(mem(a + 32'(j)));
    endtask

    // Ring walk: each burst takes min(256, words left to END), then wraps to START.
    task automatic model_ring(input logic [31:0] s, input logic [31:0] e, input int n);
        logic [31:0] a;
        logic [31:0] l;
        for (int i = 0; i < n; i++) begin
            a = model_ptr;
            l = (e - a > 32'd255) ? 32'd255 : e - a;
            model_burst(a, l[7:0], int'(l) + 1);
            model_ptr = (a + l + 32'd1 > e) ? s : a + l + 32'd1;
        end
    endtask

    task automatic restart(input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        #1;
        wr_capture_on   = 1'b0;
        START_READ_ADDR = s;
        END_READ_ADDR   = e;
        wr_capture_rst  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        wr_capture_rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        model_ptr = s;
    endtask

    task automatic wait_ars(input string tag, input int target);
        int c = 0;
        while (ar_addr_q.size() < target && c < 3000 * 5) begin
            @(negedge clk);
            #1;
            c++;
        end
        check({tag, "_ar_wait"}, 32'(int'(ar_addr_q.size() >= target)), 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int c = 0;
        int q = 0;
        while (q < 10 && c < 4000) begin
            @(negedge clk);
            #1;
            c++;
            if (sl_addr_q.size() == 0 && MASTER_RD_ADDR_VALID !== 1'b1) q++;
            else q = 0;
        end
        check({tag, "_quiet"}, 32'(q), 32'd10);
    endtask

    task automatic compare(input string tag, input int ar0, input int w0,
                           input int m0, input int d0, input int s0);
        int bad_ar = 0;
        int bad_w = 0;
        check({tag, "_ar_count"}, 32'(ar_addr_q.size() - ar0), 32'(exp_addr_q.size()));
        if (ar_addr_q.size() > ar0 && exp_addr_q.size() > 0)
            check({tag, "_ar0_addr"}, ar_addr_q[ar0], exp_addr_q[0]);
        foreach (exp_addr_q[i])
            if (ar0 + i < ar_addr_q.size())
                if (ar_addr_q[ar0 + i] !== exp_addr_q[i] || ar_len_q[ar0 + i] !== exp_len_q[i])
                    bad_ar++;
        check({tag, "_ar_fields_bad"}, 32'(bad_ar), 32'd0);
        check({tag, "_push_count"}, 32'(word_q.size() - w0), 32'(exp_word_q.size()));
        foreach (exp_word_q[i])
            if (w0 + i < word_q.size())
                if (word_q[w0 + i] !== exp_word_q[i]) bad_w++;
        check({tag, "_words_bad"}, 32'(bad_w), 32'd0);
        check({tag, "_rready_mirror"}, 32'(mirror_err - m0), 32'd0);
        check({tag, "_push_vs_r"}, 32'(data_err - d0), 32'd0);
        check({tag, "_ar_stable"}, 32'(ar_stab_err - s0), 32'd0);
        exp_addr_q.delete();
        exp_len_q.delete();
        exp_word_q.delete();
    endtask

    task automatic run(input string tag, input logic [31:0] s, input logic [31:0] e,
                       input bit from_start, input int n_ar, input int rmode);
        int ar0, w0, m0, d0, s0;
        ready_mode = rmode;
        if (from_start) restart(s, e);
        ar0 = ar_addr_q.size();
        w0  = word_q.size();
        m0  = mirror_err;
        d0  = data_err;
        s0  = ar_stab_err;
        model_ring(s, e, n_ar);
        wr_capture_on = 1'b1;
        wait_ars(tag, ar0 + n_ar);
        wr_capture_on = 1'b0;
        wait_quiet(tag);
        compare(tag, ar0, w0, m0, d0, s0);
    endtask

    initial begin
        int ar0, w0, m0, d0, s0, c;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_arvalid", 32'(MASTER_RD_ADDR_VALID), 32'd0);
        check("rst_rready", 32'(MASTER_RD_DATA_READY), 32'd0);
        check("rst_wr_valid", 32'(wr_data_valid), 32'd0);
        check("rst_araddr", MASTER_RD_ADDR, 32'd0);
        check("rst_arlen", 32'(MASTER_RD_ADDR_LEN), 32'd0);
        check("rst_master_rstn", 32'(MASTER_RSTN), 32'd0);
        check("rd_id_burst", 32'({MASTER_RD_ADDR_ID, MASTER_RD_ADDR_BURST}), 32'h1);
        check("wr_tieoff_ctrl", 32'({MASTER_WR_ADDR_ID, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
                                     MASTER_WR_ADDR_VALID, MASTER_WR_DATA_STRB, MASTER_WR_DATA_LAST,
                                     MASTER_WR_DATA_VALID, MASTER_WR_BACK_READY}), 32'h1);
        check("wr_tieoff_addr", MASTER_WR_ADDR, 32'd0);
        check("wr_tieoff_data", MASTER_WR_DATA, 32'd0);
        check("wr_clk", 32'(wr_clk), 32'(clk));
        check("master_clk", 32'(MASTER_CLK), 32'(clk));
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rel_master_rstn", 32'(MASTER_RSTN), 32'd1);
        check("idle_arvalid_off", 32'(MASTER_RD_ADDR_VALID), 32'd0);

        // 1K ring, full bursts, then wrap to the start.
        run("ring1k", 32'h0, 32'h3FF, 1'b1, 5, 0);
        // Short last burst, FIFO ready toggling every cycle.
        run("partial", 32'h10, 32'h11F, 1'b1, 3, 1);

        // Restart pulse landing on the 100th beat of a 256-beat burst.
        restart(32'h0, 32'h3FF);
        ready_mode = 0;
        ar0 = ar_addr_q.size();
        w0  = word_q.size();
        m0  = mirror_err;
        d0  = data_err;
        s0  = ar_stab_err;
        c   = dropped_beats;
        model_burst(32'h0, 8'hFF, 100);
        model_burst(32'h0, 8'hFF, 256);
        model_ptr = 32'h100;
        wr_capture_on = 1'b1;
        for (int i = 0; i < 5000 && (word_q.size() - w0) < 100; i++) begin
            @(negedge clk);
            #1;
        end
        check("drop_reach100", 32'(word_q.size() - w0), 32'd100);
        expect_drop    = 1'b1;
        wr_capture_rst = 1'b1;
        @(posedge clk);
        #1;
        wr_capture_rst = 1'b0;
        wait_ars("drop", ar0 + 2);
        wr_capture_on = 1'b0;
        wait_quiet("drop");
        expect_drop = 1'b0;
        check("drop_beats", 32'(dropped_beats - c), 32'd156);
        compare("drop", ar0, w0, m0, d0, s0);

        // Capture paused right after an AR: burst completes, resumes at held address.
        run("hold1", 32'h0, 32'h3FF, 1'b0, 1, 2);
        run("hold2", 32'h0, 32'h3FF, 1'b0, 2, 2);
        // Degenerate window of one word.
        run("single", 32'h40, 32'h40, 1'b1, 4, 2);

        // rstn asserted mid-burst: outputs return to reset values at once.
        restart(32'h0, 32'h3FF);
        ready_mode = 0;
        w0 = word_q.size();
        wr_capture_on = 1'b1;
        for (int i = 0; i < 5000 && (word_q.size() - w0) < 30; i++) begin
            @(negedge clk);
            #1;
        end
        check("mid_rst_started", 32'(int'((word_q.size() - w0) >= 30)), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_arvalid", 32'(MASTER_RD_ADDR_VALID), 32'd0);
        check("mid_rst_rready", 32'(MASTER_RD_DATA_READY), 32'd0);
        check("mid_rst_wr_valid", 32'(wr_data_valid), 32'd0);
        check("mid_rst_araddr", MASTER_RD_ADDR, 32'd0);
        check("mid_rst_arlen", 32'(MASTER_RD_ADDR_LEN), 32'd0);
        check("mid_rst_master_rstn", 32'(MASTER_RSTN), 32'd0);
        wr_capture_on = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        run("post_rst", 32'h20, 32'h2F, 1'b1, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
